fmps_test_stream_gen: RTL



---
 rtl/fmps_test_pkg.sv | 54 +++++
 rtl/fmps_next_channel.sv | 33 +++
 rtl/fmps_test_stream_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fmps_test_pkg.sv
// fmps_test_pkg: shared types, word-field positions and word builders for the FMPS
// test-packet generator.
// Optional build macro FMPS_TEST_CHECKSUM_EN adds the StCheck state (XOR checksum word).
package fmps_test_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StData,
    StNext
`ifdef FMPS_TEST_CHECKSUM_EN
    , StCheck
`endif
  } fmpsStateT;

  localparam logic [15:0] DEFAULT_MAGIC = 16'hB6CF;

  // Header word: {MAGIC, 1'b0, index, seq[9:0]}
  localparam int unsigned MAGIC_START_BIT   = 16;
  localparam int unsigned INDEX_START_BIT   = 10;
  localparam int unsigned INDEX_FIELD_WIDTH = 5;
  localparam int unsigned SEQ_START_BIT     = 0;
  localparam int unsigned SEQ_FIELD_WIDTH   = 10;

  // Data word: {seq[15:0], 3'b0, channel, k}
  localparam int unsigned DATA_SEQ_START_BIT  = 16;
  localparam int unsigned DATA_CHAN_START_BIT = 8;
  localparam int unsigned CHAN_FIELD_WIDTH    = 5;
  localparam int unsigned DATA_K_START_BIT    = 0;
  localparam int unsigned DATA_K_FIELD_WIDTH  = 8;

  function automatic logic [31:0] headerWord(input logic [15:0]                  magic,
                                             input logic [INDEX_FIELD_WIDTH-1:0] index,
                                             input logic [SEQ_FIELD_WIDTH-1:0]   seq);
    logic [31:0] w;
    w = '0;
    w[MAGIC_START_BIT +: 16]               = magic;
    w[INDEX_START_BIT +: INDEX_FIELD_WIDTH] = index;
    w[SEQ_START_BIT +: SEQ_FIELD_WIDTH]     = seq;
    return w;
  endfunction

  function automatic logic [31:0] dataWord(input logic [15:0]                   seq,
                                           input logic [CHAN_FIELD_WIDTH-1:0]   chan,
                                           input logic [DATA_K_FIELD_WIDTH-1:0] k);
    logic [31:0] w;
    w = '0;
    w[DATA_SEQ_START_BIT +: 16]               = seq;
    w[DATA_CHAN_START_BIT +: CHAN_FIELD_WIDTH] = chan;
    w[DATA_K_START_BIT +: DATA_K_FIELD_WIDTH]  = k;
    return w;
  endfunction

endpackage

// File: rtl/fmps_next_channel.sv
// fmps_next_channel: combinational search for the lowest set mask bit strictly above
// 'position', or the lowest set bit overall when 'fromStart' is high.
// Ports:
//   mask        - channel mask to search
//   position    - current channel (ignored when fromStart)
//   fromStart   - search from bit 0 inclusive
//   nextChannel - selected channel number (0 when noneLeft)
//   noneLeft    - no qualifying bit found
module fmps_next_channel
  import fmps_test_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4
) (
  input  logic [NUM_CHANNELS-1:0]     mask,
  input  logic [CHAN_FIELD_WIDTH-1:0] position,
  input  logic                        fromStart,
  output logic [CHAN_FIELD_WIDTH-1:0] nextChannel,
  output logic                        noneLeft
);

  // Scan downwards so the lowest qualifying bit is the last one written.
  always_comb begin
    nextChannel = '0;
    noneLeft    = 1'b1;
    for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
      if (mask[c] && (fromStart || (c > int'(position)))) begin
        nextChannel = CHAN_FIELD_WIDTH'(c);
        noneLeft    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fmps_test_stream_gen.sv
// fmps_test_stream_gen: on each FA strobe emits one AXI-Stream packet per enabled channel
// (header word + NUM_DATA_WORDS data words) in the Aurora user-clock domain.
// Optional build macro FMPS_TEST_CHECKSUM_EN appends an XOR checksum word to each packet.
// Ports:
//   auroraUserClk/auroraUserReset - clock, synchronous active-high reset
//   auroraFAstrobe                - single-cycle burst start
//   auroraChannelUp, enable       - start qualifiers; link loss ends the burst after tlast
//   channelMask, firstIndex       - latched at burst start
//   tdata/tvalid/tlast/tready     - AXI-Stream master
//   busy                          - burst in progress
//   overrunCount                  - strobes dropped while busy (saturating)
//   packetCount                   - completed packets (wrapping)
module fmps_test_stream_gen
  import fmps_test_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned NUM_DATA_WORDS = 1,
  parameter logic [15:0] MAGIC          = DEFAULT_MAGIC,
  parameter int unsigned INDEX_WIDTH    = 5,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                    auroraUserClk,
  input  logic                    auroraUserReset,
  input  logic                    auroraFAstrobe,
  input  logic                    auroraChannelUp,
  input  logic                    enable,
  input  logic [NUM_CHANNELS-1:0] channelMask,
  input  logic [INDEX_WIDTH-1:0]  firstIndex,
  output logic [31:0]             tdata,
  output logic                    tvalid,
  output logic                    tlast,
  input  logic                    tready,
  output logic                    busy,
  output logic [COUNT_WIDTH-1:0]  overrunCount,
  output logic [COUNT_WIDTH-1:0]  packetCount
);

  localparam logic [7:0] LAST_K = 8'(NUM_DATA_WORDS - 1);

  fmpsStateT                   state;
  logic [NUM_CHANNELS-1:0]     maskQ;
  logic [INDEX_WIDTH-1:0]      firstIndexQ;
  logic [CHAN_FIELD_WIDTH-1:0] curChan;
  logic [15:0]                 seq;
  logic [7:0]                  wordIdx;
  logic                        linkLost;
`ifdef FMPS_TEST_CHECKSUM_EN
  logic [31:0]                 acc;
`endif

  logic                        startBurst;
  logic                        continueBurst;
  logic [NUM_CHANNELS-1:0]     searchMask;
  logic [CHAN_FIELD_WIDTH-1:0] nextChan;
  logic                        noneLeft;
  logic [INDEX_WIDTH-1:0]      hdrIndex;
  logic [15:0]                 hdrSeq;
  logic [31:0]                 hdrWord;
  logic [7:0]                  dataK;
  logic [31:0]                 dataW;
`ifndef FMPS_TEST_CHECKSUM_EN
  logic                        isLastData;
`endif

  assign busy       = (state != StIdle);
  assign startBurst = auroraFAstrobe && enable && auroraChannelUp && (|channelMask);

  // In idle the search runs on the live mask (burst start), otherwise on the latched one.
  assign searchMask = (state == StIdle) ? channelMask : maskQ;

  fmps_next_channel #(
    .NUM_CHANNELS(NUM_CHANNELS)
  ) u_next_channel (
    .mask       (searchMask),
    .position   (curChan),
    .fromStart  (state == StIdle),
    .nextChannel(nextChan),
    .noneLeft   (noneLeft)
  );

  assign continueBurst = !noneLeft && !linkLost && auroraChannelUp;

  assign hdrIndex = ((state == StIdle) ? firstIndex : firstIndexQ) + INDEX_WIDTH'(nextChan);
  assign hdrSeq   = (state == StIdle) ? seq + 16'd1 : seq;
  assign hdrWord  = headerWord(MAGIC, INDEX_FIELD_WIDTH'(hdrIndex),
                               hdrSeq[SEQ_FIELD_WIDTH-1:0]);

  assign dataK = (state == StHeader) ? 8'd0 : wordIdx + 8'd1;
  assign dataW = dataWord(seq, curChan, dataK);
`ifndef FMPS_TEST_CHECKSUM_EN
  assign isLastData = (dataK == LAST_K);
`endif

  always_ff @(posedge auroraUserClk) begin
    if (auroraUserReset) begin
      state        <= StIdle;
      tdata        <= '0;
      tvalid       <= 1'b0;
      tlast        <= 1'b0;
      overrunCount <= '0;
      packetCount  <= '0;
      seq          <= '0;
      maskQ        <= '0;
      firstIndexQ  <= '0;
      curChan      <= '0;
      wordIdx      <= '0;
      linkLost     <= 1'b0;
`ifdef FMPS_TEST_CHECKSUM_EN
      acc          <= '0;
`endif
    end else begin
      if (auroraFAstrobe && busy && (overrunCount != '1)) begin
        overrunCount <= overrunCount + COUNT_WIDTH'(1);
      end
      // Sticky so a brief link drop anywhere in a packet still ends the burst.
      if (busy && !auroraChannelUp) begin
        linkLost <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (startBurst) begin
            maskQ       <= channelMask;
            firstIndexQ <= firstIndex;
            seq         <= hdrSeq;
            curChan     <= nextChan;
            linkLost    <= 1'b0;
            tdata       <= hdrWord;
            tvalid      <= 1'b1;
            tlast       <= 1'b0;
            state       <= StHeader;
`ifdef FMPS_TEST_CHECKSUM_EN
            acc         <= hdrWord;
`endif
          end
        end

        StHeader, StData: begin
          if (tready) begin
`ifdef FMPS_TEST_CHECKSUM_EN
            if ((state == StData) && (wordIdx == LAST_K)) begin
              tdata <= acc;
              tlast <= 1'b1;
              state <= StCheck;
            end else begin
              wordIdx <= dataK;
              tdata   <= dataW;
              acc     <= acc ^ dataW;
              state   <= StData;
            end
`else
            wordIdx <= dataK;
            tdata   <= dataW;
            tlast   <= isLastData;
            state   <= isLastData ? StNext : StData;
`endif
          end
        end

        // Final beat of a packet is on the bus; its handshake picks the next channel.
`ifdef FMPS_TEST_CHECKSUM_EN
        StCheck,
`endif
        StNext: begin
          if (tready) begin
            packetCount <= packetCount + COUNT_WIDTH'(1);
            if (continueBurst) begin
              curChan <= nextChan;
              tdata   <= hdrWord;
              tlast   <= 1'b0;
              state   <= StHeader;
`ifdef FMPS_TEST_CHECKSUM_EN
              acc     <= hdrWord;
`endif
            end else begin
              tdata  <= '0;
              tvalid <= 1'b0;
              tlast  <= 1'b0;
              state  <= StIdle;
            end
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule
